// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the core stage sequencer
package core_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_TRAP  = 3'd4
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CTRL_EXEC = 2'd0,
        CTRL_MEM  = 2'd1,
        CTRL_AMO  = 2'd2
    } ctrl_path_e;

endpackage

// File: rtl/core_flop.sv
// rtl/core_flop.sv - generic D flop bank with async active-low reset
module core_flop #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/core_stage_ctrl_perf.sv
// rtl/core_stage_ctrl_perf.sv - free-running cycle and stall counters
module core_stage_ctrl_perf #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    output logic [CNT_W-1:0] perf_cycle_o,
    output logic [CNT_W-1:0] perf_stall_o
);

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign cycle_d = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign stall_d = stall_q + {{(CNT_W-1){1'b0}}, stall_i};

    core_flop #(.W(CNT_W)) u_cycle_flop (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cycle_d),
        .q_o   (cycle_q)
    );

    core_flop #(.W(CNT_W)) u_stall_flop (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (stall_d),
        .q_o   (stall_q)
    );

    assign perf_cycle_o = cycle_q;
    assign perf_stall_o = stall_q;

endmodule

// File: rtl/core_stage_ctrl.sv
// rtl/core_stage_ctrl.sv - FETCH/EXEC/MEM/WB sequencer with AMO two-pass and trap steering
// Perf counters are built only when CORE_STAGE_CTRL_PERF_EN is defined.
module core_stage_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             fetch_stage_valid,
    input  logic             fetch_stage_ready,
    output logic             exec_stage_valid,
    input  logic             exec_stage_ready,
    output logic             exec_phase,
    input  logic [1:0]       ctrl_path,
    output logic             mem_stage_valid,
    input  logic             mem_stage_ready,
    input  logic             exec_ex,
    input  logic             mem_ex,
    input  logic             irq_pending,
    output logic             reg_wr_en,
    output logic             trap_valid,
    output logic             instret,
    output logic [CNT_W-1:0] perf_cycle,
    output logic [CNT_W-1:0] perf_stall
);

    ctrl_state_e state_q, state_d;
    logic [2:0]  state_q_raw;
    logic        phase_q, phase_d;
    logic [1:0]  path_q, path_d;

    core_flop #(.W(3), .RST_VAL(S_FETCH)) u_state_flop (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (state_d),
        .q_o   (state_q_raw)
    );
    assign state_q = ctrl_state_e'(state_q_raw);

    core_flop #(.W(1)) u_phase_flop (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (phase_d),
        .q_o   (phase_q)
    );

    core_flop #(.W(2), .RST_VAL(CTRL_EXEC)) u_path_flop (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (path_d),
        .q_o   (path_q)
    );

    always_comb begin
        state_d           = state_q;
        phase_d           = phase_q;
        path_d            = path_q;
        fetch_stage_valid = 1'b0;
        exec_stage_valid  = 1'b0;
        exec_phase        = 1'b0;
        mem_stage_valid   = 1'b0;
        reg_wr_en         = 1'b0;
        instret           = 1'b0;
        trap_valid        = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Interrupts are only taken between instructions, before a fetch goes out
                if (irq_pending) begin
                    state_d = S_TRAP;
                end else begin
                    fetch_stage_valid = 1'b1;
                    if (fetch_stage_ready) begin
                        state_d = S_EXEC;
                        phase_d = 1'b0;
                    end
                end
            end
            S_EXEC: begin
                exec_stage_valid = 1'b1;
                exec_phase       = phase_q;
                if (exec_stage_ready) begin
                    if (exec_ex) begin
                        state_d = S_TRAP;
                    end else if (phase_q) begin
                        state_d = S_MEM;
                    end else begin
                        path_d = ctrl_path;
                        case (ctrl_path)
                            CTRL_EXEC:          state_d = S_WB;
                            CTRL_MEM, CTRL_AMO: state_d = S_MEM;
                            default:            state_d = S_TRAP;
                        endcase
                    end
                end
            end
            S_MEM: begin
                mem_stage_valid = 1'b1;
                if (mem_stage_ready) begin
                    if (mem_ex) begin
                        state_d = S_TRAP;
                    end else if (path_q == CTRL_AMO && !phase_q) begin
                        state_d = S_EXEC;
                        phase_d = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_wr_en = 1'b1;
                instret   = 1'b1;
                state_d   = S_FETCH;
                phase_d   = 1'b0;
            end
            S_TRAP: begin
                trap_valid = 1'b1;
                state_d    = S_FETCH;
                phase_d    = 1'b0;
            end
            default: begin
                state_d = S_FETCH;
                phase_d = 1'b0;
            end
        endcase
    end

`ifdef CORE_STAGE_CTRL_PERF_EN
    logic stall;
    assign stall = (fetch_stage_valid && !fetch_stage_ready) ||
                   (exec_stage_valid  && !exec_stage_ready)  ||
                   (mem_stage_valid   && !mem_stage_ready);

    core_stage_ctrl_perf #(.CNT_W(CNT_W)) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .perf_cycle_o (perf_cycle),
        .perf_stall_o (perf_stall)
    );
`else
    assign perf_cycle = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_core_stage_ctrl.sv
// tb/tb_core_stage_ctrl.sv - scoreboard bench for core_stage_ctrl
module tb_core_stage_ctrl;

    localparam int CNT_W = 64;
    localparam int EV_F = 1, EV_E0 = 2, EV_E1 = 3, EV_M = 4, EV_WB = 5, EV_T = 6, EV_BAD = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fetch_stage_valid, fetch_stage_ready;
    logic             exec_stage_valid, exec_stage_ready, exec_phase;
    logic [1:0]       ctrl_path;
    logic             mem_stage_valid, mem_stage_ready;
    logic             exec_ex, mem_ex, irq_pending;
    logic             reg_wr_en, trap_valid, instret;
    logic [CNT_W-1:0] perf_cycle, perf_stall;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    core_stage_ctrl #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_stage_valid (fetch_stage_valid),
        .fetch_stage_ready (fetch_stage_ready),
        .exec_stage_valid  (exec_stage_valid),
        .exec_stage_ready  (exec_stage_ready),
        .exec_phase        (exec_phase),
        .ctrl_path         (ctrl_path),
        .mem_stage_valid   (mem_stage_valid),
        .mem_stage_ready   (mem_stage_ready),
        .exec_ex           (exec_ex),
        .mem_ex            (mem_ex),
        .irq_pending       (irq_pending),
        .reg_wr_en         (reg_wr_en),
        .trap_valid        (trap_valid),
        .instret           (instret),
        .perf_cycle        (perf_cycle),
        .perf_stall        (perf_stall)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

`ifdef CORE_STAGE_CTRL_PERF_EN
    logic [CNT_W-1:0] ref_cyc;
    longint           ref_stall;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_cyc <= '0;
        else        ref_cyc <= ref_cyc + 1;
    end
    always @(negedge clk) begin
        if (!rst_n) ref_stall = 0;
        else if ((fetch_stage_valid && !fetch_stage_ready) || (exec_stage_valid && !exec_stage_ready) ||
                 (mem_stage_valid && !mem_stage_ready))
            ref_stall++;
    end
`endif

    // Monitor: turns DUT handshakes/strobes into events and pops the scoreboard
    always @(negedge clk) begin : monitor
        int ev;
        if (mon_en && rst_n) begin
            ev = 0;
            if (fetch_stage_valid && fetch_stage_ready) ev = EV_F;
            if (exec_stage_valid && exec_stage_ready) ev = (ev != 0) ? EV_BAD : (exec_phase ? EV_E1 : EV_E0);
            if (mem_stage_valid && mem_stage_ready) ev = (ev != 0 || exec_phase) ? EV_BAD : EV_M;
            if (reg_wr_en || instret || trap_valid) begin
                if (ev != 0) ev = EV_BAD;
                else if (reg_wr_en && instret && !trap_valid) ev = EV_WB;
                else if (trap_valid && !reg_wr_en && !instret) ev = EV_T;
                else ev = EV_BAD;
            end
            if (ev != 0) begin
                if (exp_q.size() == 0) check("unexpected_event", ev, 0);
                else check("event", ev, exp_q.pop_front());
            end
        end
    end

    // One instruction: push expected event list, then drive until WB/TRAP strobe
    task automatic run_instr(input bit irq, input int path, input int eex, input int mex,
                             input bit all_ready, input int mem_stall);
        int  evs[$];
        int  ecnt = 0, mcnt = 0, cyc = 0, hold = 0, mvc = 0;
        bit  fetched = 1'b0, done = 1'b0;
        longint p0;
        if (irq) evs.push_back(EV_T);
        else begin
            evs.push_back(EV_F);
            evs.push_back(EV_E0);
            if (eex == 0 || path == 3) evs.push_back(EV_T);
            else if (path == 0) evs.push_back(EV_WB);
            else begin
                evs.push_back(EV_M);
                if (mex == 0) evs.push_back(EV_T);
                else if (path == 1) evs.push_back(EV_WB);
                else begin
                    evs.push_back(EV_E1);
                    if (eex == 1) evs.push_back(EV_T);
                    else begin
                        evs.push_back(EV_M);
                        evs.push_back((mex == 1) ? EV_T : EV_WB);
                    end
                end
            end
        end
        foreach (evs[k]) exp_q.push_back(evs[k]);
        p0 = longint'(perf_stall);
        while (!done && cyc < 80) begin
            irq_pending = fetched ? 1'($urandom_range(0, 1)) : irq;
            #1;
            fetch_stage_ready = all_ready || ($urandom_range(0, 3) != 0);
            exec_stage_ready  = all_ready || ($urandom_range(0, 3) != 0);
            mem_stage_ready   = all_ready || ($urandom_range(0, 3) != 0);
            if (mem_stage_valid && hold < mem_stall) begin
                mem_stage_ready = 1'b0;
                hold++;
            end
            ctrl_path = (ecnt == 0) ? path[1:0] : 2'($urandom_range(0, 3));
            exec_ex   = exec_stage_valid ? (ecnt == eex) : 1'($urandom_range(0, 1));
            mem_ex    = mem_stage_valid ? (mcnt == mex) : 1'($urandom_range(0, 1));
            #1;
            if (fetch_stage_valid && fetch_stage_ready) fetched = 1'b1;
            if (exec_stage_valid && exec_stage_ready) ecnt++;
            if (mem_stage_valid && mem_stage_ready) mcnt++;
            if (mem_stage_valid) mvc++;
            if (reg_wr_en || trap_valid) done = 1'b1;
            cyc++;
            @(posedge clk);
            #1;
        end
        check("instr_done", done, 1);
        if (all_ready) check("latency", cyc, evs.size() + (irq ? 1 : 0) + mem_stall);
        if (mem_stall > 0) begin
            check("mem_valid_cycles", mvc, mem_stall + 1);
`ifdef CORE_STAGE_CTRL_PERF_EN
            check("perf_stall_delta", longint'(perf_stall) - p0, mem_stall);
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_stage_ready = 1'b0; exec_stage_ready = 1'b0; mem_stage_ready = 1'b0;
        ctrl_path = 2'd0; exec_ex = 1'b0; mem_ex = 1'b0; irq_pending = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fetch_valid", fetch_stage_valid, 1);
        check("rst_exec_valid", exec_stage_valid, 0);
        check("rst_mem_valid", mem_stage_valid, 0);
        check("rst_exec_phase", exec_phase, 0);
        check("rst_strobes", {reg_wr_en, instret, trap_valid}, 0);
        check("rst_perf_cycle", longint'(perf_cycle), 0);
        check("rst_perf_stall", longint'(perf_stall), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_instr(0, 0, -1, -1, 1, 0);   // ADD
        run_instr(0, 1, -1, -1, 1, 0);   // LW
        run_instr(0, 2, -1, -1, 1, 0);   // AMOADD
        run_instr(0, 0, -1, -1, 1, 0);   // SC with lost reservation
        run_instr(0, 1, -1, -1, 1, 5);   // LW, MEM held off 5 cycles
        run_instr(0, 1, 0, -1, 1, 0);    // exception on EXEC handshake
        run_instr(0, 2, -1, 0, 1, 0);    // AMO fault on first MEM pass
        run_instr(0, 2, 1, -1, 1, 0);    // AMO exception on second EXEC
        run_instr(0, 2, -1, 1, 1, 0);    // AMO fault on second MEM pass
        run_instr(1, 0, -1, -1, 1, 0);   // interrupt at FETCH
        run_instr(0, 3, -1, -1, 1, 0);   // illegal ctrl_path

        // Reset while the MEM stage is stalled
        mon_en = 1'b0;
        fetch_stage_ready = 1'b1; exec_stage_ready = 1'b1; mem_stage_ready = 1'b0;
        ctrl_path = 2'd1; exec_ex = 1'b0; mem_ex = 1'b0; irq_pending = 1'b0;
        for (int c = 0; c < 20 && !mem_stage_valid; c++) begin
            @(posedge clk);
            #1;
        end
        check("mem_reached", mem_stage_valid, 1);
        fetch_stage_ready = 1'b0; exec_stage_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_fetch_valid", fetch_stage_valid, 1);
        check("midrst_mem_valid", mem_stage_valid, 0);
        check("midrst_strobes", {reg_wr_en, instret, trap_valid}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 300; i++) begin
            int r, p, e, m;
            bit q;
            r = $urandom_range(0, 9);
            p = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            r = $urandom_range(0, 7);
            e = (r == 0) ? 0 : (r == 1) ? 1 : -1;
            r = $urandom_range(0, 7);
            m = (r == 0) ? 0 : (r == 1) ? 1 : -1;
            q = ($urandom_range(0, 9) == 0);
            run_instr(q, p, e, m, 0, 0);
        end

        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
`ifdef CORE_STAGE_CTRL_PERF_EN
        check("perf_cycle_final", longint'(perf_cycle), longint'(ref_cyc));
        check("perf_stall_final", longint'(perf_stall), ref_stall);
`else
        check("perf_cycle_tied", longint'(perf_cycle), 0);
        check("perf_stall_tied", longint'(perf_stall), 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
